fb_port_arbiter: RTL and testbench

Single-clock arbiter that shares one single-port 2-bit framebuffer RAM between three agents: the display read stream, the PPU pixel write stream, and a clear engine that fills the whole frame with one colour. It sits between the PPU/display timing logic and the framebuffer RAM. It absorbs PPU write bursts in a small FIFO, guarantees the display a read slot every cycle it asks, and flags any PPU write that was lost.

---
 rtl/fb_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// Shares one single-port 2-bit framebuffer RAM between display reads, a PPU
// write FIFO and a full-frame clear engine. Fixed priority: read > clear > FIFO.
module fb_port_arbiter #(
  parameter int DEPTH      = 23040,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  output logic              wr_ovf,
  input  logic              ovf_clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [1:0]        rd_data,
  input  logic              clr_start,
  input  logic [1:0]        clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [1:0]        ram_din,
  input  logic [1:0]        ram_dout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        data;
  } wr_ent_t;

  typedef enum logic {IDLE, CLEAR} clr_st_t;

  wr_ent_t           fifo_q [FIFO_DEPTH];
  wr_ent_t           head;
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt;
  logic              full, empty;
  logic              wr_in_range, rd_in_range;
  logic              push, pop, overflow;
  logic              rd_hit, rd_hit_q;
  logic              gnt_clr, gnt_fifo;
  clr_st_t           st;
  logic [ADDR_W-1:0] clr_ptr;
  logic [1:0]        clr_col_q;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

  assign full     = (cnt == CW'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign wr_ready = !full;
  assign head     = fifo_q[rptr];

  // Out-of-range writes vanish silently, so they never count as overflow.
  assign push     = wr_valid && !full && wr_in_range;
  assign overflow = wr_valid &&  full && wr_in_range;

  // Reset gates the read grant so the RAM port idles while rst is held.
  assign rd_hit   = rd_req && rd_in_range && rst;
  assign gnt_clr  = clr_busy && !rd_hit;
  assign gnt_fifo = !empty && !rd_hit && !clr_busy;
  assign pop      = gnt_fifo;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      wr_ovf <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (overflow)     wr_ovf <= 1'b1;
      else if (ovf_clr) wr_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_hit_q <= rd_hit;
    end
  end

  // The RAM output is already registered, so it lines up with rd_valid.
  assign rd_data = rd_hit_q ? ram_dout : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      clr_ptr   <= '0;
      clr_col_q <= '0;
    end else begin
      clr_done <= 1'b0;
      case (st)
        IDLE: if (clr_start) begin
          st        <= CLEAR;
          clr_busy  <= 1'b1;
          clr_ptr   <= '0;
          clr_col_q <= clr_color;
        end
        CLEAR: if (gnt_clr) begin
          if (clr_ptr == LAST) begin
            st       <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = 2'b00;
    if (rd_hit) begin
      ram_addr = rd_addr;
    end else if (gnt_clr) begin
      ram_addr = clr_ptr;
      ram_we   = 1'b1;
      ram_din  = clr_col_q;
    end else if (gnt_fifo) begin
      ram_addr = head.addr;
      ram_we   = 1'b1;
      ram_din  = head.data;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus a randomized run against a
// queue-based model of the grant rules, with a synchronous-read RAM attached.
module tb_fb_port_arbiter;
  localparam int DEPTH = 23040;
  localparam int AW    = 15;

  logic          clk, rst;
  logic          wr_valid, wr_ready, wr_ovf, ovf_clr;
  logic [AW-1:0] wr_addr, rd_addr, ram_addr;
  logic [1:0]    wr_data, rd_data, clr_color, ram_din, ram_dout;
  logic          rd_req, rd_valid, clr_start, clr_busy, clr_done, ram_we;

  int checks = 0;
  int errors = 0;

  fb_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ovf(wr_ovf), .ovf_clr(ovf_clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 2'b00;
    ram_dout = 2'b00;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = 0; wr_addr = '0; wr_data = '0; ovf_clr = 0;
    rd_req = 0; rd_addr = '0; clr_start = 0; clr_color = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2 rst = 0;
    rd_req = 1; rd_addr = 15'd5;
    cyc(); cyc();
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL reset_wr_ovf got %0b want 0", wr_ovf); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    checks++; if (rd_data !== 2'b00) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr got busy=%0b done=%0b want 0 0", clr_busy, clr_done); end
    checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== 2'b00) begin errors++; $display("FAIL reset_ram got we=%0b addr=%0d din=%0d want 0 0 0", ram_we, ram_addr, ram_din); end
    @(negedge clk);
    rst = 1; idle();
    cyc();
  endtask

  task automatic test_single();
    wr_valid = 1; wr_addr = 15'd5; wr_data = 2'd2;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_no_early_write got we=%0b want 0", ram_we); end
    cyc(); idle(); #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 15'd5 || ram_din !== 2'd2) begin errors++; $display("FAIL single_write got we=%0b addr=%0d din=%0d want 1 5 2", ram_we, ram_addr, ram_din); end
    cyc();
    rd_req = 1; rd_addr = 15'd5; #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 15'd5) begin errors++; $display("FAIL single_read_port got we=%0b addr=%0d want 0 5", ram_we, ram_addr); end
    cyc(); idle(); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 2'd2) begin errors++; $display("FAIL single_read_data got v=%0b d=%0d want 1 2", rd_valid, rd_data); end
    cyc(); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_rd_valid_drop got %0b want 0", rd_valid); end
  endtask

  task automatic test_stall();
    int writes = 0;
    rd_req = 1; rd_addr = 15'd100;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 15'(200 + i); wr_data = 2'((i + 1) % 4);
      #1;
      if (ram_we) writes++;
      checks++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL stall_wr_ready_%0d got %0b want %0b", i, wr_ready, (i < 4)); end
      cyc();
    end
    wr_valid = 0; #1;
    if (ram_we) writes++;
    checks++; if (wr_ovf !== 1'b1) begin errors++; $display("FAIL stall_ovf_set got %0b want 1", wr_ovf); end
    checks++; if (writes != 0) begin errors++; $display("FAIL stall_no_writes got %0d writes want 0", writes); end
    cyc();
    rd_req = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 15'(200 + k) || ram_din !== 2'((k + 1) % 4)) begin
        errors++; $display("FAIL stall_retire_%0d got we=%0b addr=%0d din=%0d want 1 %0d %0d", k, ram_we, ram_addr, ram_din, 200 + k, (k + 1) % 4);
      end
      cyc();
    end
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL stall_drained got we=%0b want 0", ram_we); end
    ovf_clr = 1; cyc(); ovf_clr = 0; #1;
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL stall_ovf_clr got %0b want 0", wr_ovf); end
    cyc();
  endtask

  task automatic test_oor();
    wr_valid = 1; wr_addr = 15'(DEPTH); wr_data = 2'd3; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oor_wr_ready got %0b want 1", wr_ready); end
    cyc(); idle(); #1;
    checks++; if (ram_we !== 1'b0 || wr_ovf !== 1'b0) begin errors++; $display("FAIL oor_write_dropped got we=%0b ovf=%0b want 0 0", ram_we, wr_ovf); end
    cyc();
    wr_valid = 1; wr_addr = 15'd5; wr_data = 2'd1;
    cyc(); idle();
    rd_req = 1; rd_addr = 15'd23040; #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 15'd5 || ram_din !== 2'd1) begin errors++; $display("FAIL oor_read_fifo_grant got we=%0b addr=%0d din=%0d want 1 5 1", ram_we, ram_addr, ram_din); end
    cyc(); idle(); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 2'd0) begin errors++; $display("FAIL oor_read_data got v=%0b d=%0d want 1 0", rd_valid, rd_data); end
    cyc();
  endtask

  task automatic test_full_pushpop();
    rd_req = 1; rd_addr = 15'd100;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 15'(300 + i); wr_data = 2'(3 - i);
      cyc();
    end
    rd_req = 0; wr_valid = 1; wr_addr = 15'd399; wr_data = 2'd3; #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %0b want 0", wr_ready); end
    cyc(); wr_valid = 0; #1;
    checks++; if (wr_ready !== 1'b1 || wr_ovf !== 1'b1) begin errors++; $display("FAIL full_after_pop got ready=%0b ovf=%0b want 1 1", wr_ready, wr_ovf); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 15'(300 + k) || ram_din !== 2'(3 - k)) begin
        errors++; $display("FAIL full_retire_%0d got we=%0b addr=%0d din=%0d want 1 %0d %0d", k, ram_we, ram_addr, ram_din, 300 + k, 3 - k);
      end
      cyc(); #1;
    end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL full_refused_push got we=%0b addr=%0d want 0", ram_we, ram_addr); end
    ovf_clr = 1; cyc(); ovf_clr = 0;
  endtask

  task automatic test_clear();
    int exp_ptr = 0, busy_cycles = 0, bad = 0;
    clr_start = 1; clr_color = 2'd3; #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_early got %0b want 0", clr_busy); end
    cyc(); idle(); #1;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise got %0b want 1", clr_busy); end
    for (int c = 0; c < DEPTH + 100; c++) begin
      idle();
      if (c == 10) begin clr_start = 1; clr_color = 2'd1; end
      if (c == 20) begin wr_valid = 1; wr_addr = 15'd0; wr_data = 2'd1; end
      if (c == 50 || c == 51) begin rd_req = 1; rd_addr = 15'd0; end
      #1;
      if (!clr_busy) break;
      if (c == 51 || c == 52) begin
        checks++; if (rd_valid !== 1'b1 || rd_data !== 2'd3) begin errors++; $display("FAIL clear_mid_read_%0d got v=%0b d=%0d want 1 3", c, rd_valid, rd_data); end
      end
      if (rd_req) begin
        if (ram_we !== 1'b0) bad++;
      end else begin
        if (ram_we !== 1'b1 || ram_addr !== 15'(exp_ptr) || ram_din !== 2'd3) bad++;
        exp_ptr++;
      end
      if (clr_done !== 1'b0) bad++;
      busy_cycles++;
      cyc();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_writes got %0d bad cycles want 0", bad); end
    checks++; if (busy_cycles != DEPTH + 2) begin errors++; $display("FAIL clear_duration got %0d want %0d", busy_cycles, DEPTH + 2); end
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL clear_done_pulse got %0b want 1", clr_done); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== 15'd0 || ram_din !== 2'd1) begin errors++; $display("FAIL clear_overlay_write got we=%0b addr=%0d din=%0d want 1 0 1", ram_we, ram_addr, ram_din); end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(); #1;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_single_done got %0d extra cycles want 0", bad); end
    rd_req = 1; rd_addr = 15'd0; cyc();
    rd_addr = 15'(DEPTH - 1); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 2'd1) begin errors++; $display("FAIL clear_read_addr0 got v=%0b d=%0d want 1 1", rd_valid, rd_data); end
    cyc(); idle(); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 2'd3) begin errors++; $display("FAIL clear_read_last got v=%0b d=%0d want 1 3", rd_valid, rd_data); end
    cyc();
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    int bad = 0;
    clr_start = 1; clr_color = 2'd2; cyc(); idle();
    for (int c = 0; c < 300; c++) begin
      idle();
      if (c == 3 || c == 4) begin wr_valid = 1; wr_addr = 15'(10 + c); wr_data = 2'd1; end
      #1;
      if (ram_we && ram_addr == 15'd100) begin found = 1; break; end
      cyc();
    end
    idle();
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_ptr100 got timeout want clr_ptr=100"); end
    rst = 0; #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== 2'b00) begin errors++; $display("FAIL rstmid_ram got we=%0b addr=%0d din=%0d want 0 0 0", ram_we, ram_addr, ram_din); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_ready !== 1'b1 || wr_ovf !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 2'b00) begin
      errors++; $display("FAIL rstmid_outputs got busy=%0b done=%0b ready=%0b ovf=%0b rv=%0b rd=%0d want 0 0 1 0 0 0", clr_busy, clr_done, wr_ready, wr_ovf, rd_valid, rd_data);
    end
    @(negedge clk); rst = 1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ram_we !== 1'b0 || clr_busy !== 1'b0) bad++;
      cyc();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_no_writes got %0d active cycles want 0", bad); end
  endtask

  typedef struct { logic [AW-1:0] addr; logic [1:0] data; } ent_t;

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    logic [1:0] ref_fb [64];
    bit known [64];
    bit exp_rv = 0, exp_chk = 0, exp_ovf = 0, rd_in, w_in, full;
    logic [1:0] exp_rd = 0;
    int gbad = 0, rbad = 0, sbad = 0;
    for (int i = 0; i < 64; i++) begin known[i] = 0; ref_fb[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      idle();
      rd_req = ($urandom_range(0, 2) == 0);
      rd_addr = ($urandom_range(0, 7) == 0) ? 15'(DEPTH + $urandom_range(0, 15)) : 15'($urandom_range(0, 63));
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr = (q.size() < 4 && $urandom_range(0, 15) == 0) ? 15'(DEPTH + $urandom_range(0, 7)) : 15'($urandom_range(0, 63));
      wr_data = 2'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 15) == 0);
      #1;
      if (rd_valid !== exp_rv || (exp_rv && exp_chk && rd_data !== exp_rd)) begin
        rbad++; $display("FAIL rand_read c=%0d got v=%0b d=%0d want %0b %0d", c, rd_valid, rd_data, exp_rv, exp_rd);
      end
      if (wr_ovf !== exp_ovf || wr_ready !== (q.size() < 4)) begin
        sbad++; $display("FAIL rand_status c=%0d got ovf=%0b ready=%0b want %0b %0b", c, wr_ovf, wr_ready, exp_ovf, q.size() < 4);
      end
      rd_in = rd_req && (int'(rd_addr) < DEPTH);
      w_in = int'(wr_addr) < DEPTH;
      if (rd_in) begin
        if (ram_we !== 1'b0 || ram_addr !== rd_addr) begin gbad++; $display("FAIL rand_grant_rd c=%0d got we=%0b addr=%0d want 0 %0d", c, ram_we, ram_addr, rd_addr); end
      end else if (q.size() > 0) begin
        if (ram_we !== 1'b1 || ram_addr !== q[0].addr || ram_din !== q[0].data) begin gbad++; $display("FAIL rand_grant_wr c=%0d got we=%0b addr=%0d din=%0d want 1 %0d %0d", c, ram_we, ram_addr, ram_din, q[0].addr, q[0].data); end
      end else begin
        if (ram_we !== 1'b0 || ram_addr !== '0) begin gbad++; $display("FAIL rand_grant_idle c=%0d got we=%0b addr=%0d want 0 0", c, ram_we, ram_addr); end
      end
      exp_rv = rd_req;
      exp_chk = 1; exp_rd = 0;
      if (rd_in) begin exp_chk = known[rd_addr[5:0]]; exp_rd = ref_fb[rd_addr[5:0]]; end
      full = (q.size() == 4);
      if (!rd_in && q.size() > 0) begin
        e = q.pop_front();
        ref_fb[e.addr[5:0]] = e.data; known[e.addr[5:0]] = 1;
      end
      if (wr_valid && w_in && !full) begin e.addr = wr_addr; e.data = wr_data; q.push_back(e); end
      if (wr_valid && w_in && full) exp_ovf = 1;
      else if (ovf_clr) exp_ovf = 0;
      cyc();
    end
    idle();
    checks++; if (gbad != 0) begin errors++; $display("FAIL rand_grant_total got %0d bad cycles want 0", gbad); end
    checks++; if (rbad != 0) begin errors++; $display("FAIL rand_read_total got %0d bad cycles want 0", rbad); end
    checks++; if (sbad != 0) begin errors++; $display("FAIL rand_status_total got %0d bad cycles want 0", sbad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_oor();
    test_full_pushpop();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
